fp_normalizer: RTL and testbench

- Two-stage pipelined post-arithmetic normalizer for the FPU datapath.
- Input: an unnormalized mantissa (with carry bit) and a signed exponent from the adder/multiplier.
- Output: a mantissa whose leading one sits at bit W-2 (the hidden-bit position), the adjusted exponent, and sticky/zero/tiny flags for the rounder.
- The leading-one position comes from an internal priority_encoder instance; the block sits directly downstream of it.

---
 rtl/fp_normalizer_pkg.sv | 25 ++
 rtl/fp_normalizer_if.sv | 28 ++
 rtl/fp_normalizer_priority_encoder.sv | 24 ++
 rtl/fp_normalizer.sv | 94 +++++++++
 tb/tb_fp_normalizer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/fp_normalizer_pkg.sv
// Shared widths and stage record types for the two-stage FPU post-normalizer.
// Optional build macro FP_NORMALIZER_DENORM_EN is consumed by fp_normalizer.
package fp_pkg;

    localparam int NORM_W     = 28;
    localparam int NORM_EXP_W = 10;
    localparam int HIDDEN_POS = NORM_W - 2;
    localparam int IDX_W      = $clog2(NORM_W);

    typedef struct packed {
        logic [NORM_W-1:0]            mant;
        logic signed [NORM_EXP_W-1:0] exp;
        logic [IDX_W-1:0]             idx;
        logic                         empty;
    } norm_stage1_t;

    typedef struct packed {
        logic [NORM_W-1:0]            mant;
        logic signed [NORM_EXP_W-1:0] exp;
        logic                         sticky;
        logic                         zero;
        logic                         tiny;
    } norm_result_t;

endpackage

// File: rtl/fp_normalizer_if.sv
// Valid/ready handshake bundle for fp_normalizer; master is the upstream/downstream
// environment, slave is the normalizer itself.
interface fp_normalizer_if #(
    parameter int W     = 28,
    parameter int EXP_W = 10
);
    logic             valid_in;
    logic             ready_out;
    logic [W-1:0]     mant_in;
    logic [EXP_W-1:0] exp_in;
    logic             valid_out;
    logic             ready_in;
    logic [W-1:0]     mant_out;
    logic [EXP_W-1:0] exp_out;
    logic             sticky_out;
    logic             zero_out;
    logic             tiny_out;

    modport master (
        output valid_in, mant_in, exp_in, ready_in,
        input  ready_out, valid_out, mant_out, exp_out, sticky_out, zero_out, tiny_out
    );

    modport slave (
        input  valid_in, mant_in, exp_in, ready_in,
        output ready_out, valid_out, mant_out, exp_out, sticky_out, zero_out, tiny_out
    );
endinterface

// File: rtl/fp_normalizer_priority_encoder.sv
// Combinational leading-one detector: idx is the position of the most significant
// set bit of vec, found is low when vec is all zeros.
module priority_encoder #(
    parameter int N     = 28,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_normalizer.sv
// Two-stage post-arithmetic mantissa normalizer with valid/ready flow control.
// Build macro FP_NORMALIZER_DENORM_EN clamps left shifts so the exponent stays >= 1.
module fp_normalizer
    import fp_pkg::*;
#(
    parameter int W     = NORM_W,
    parameter int EXP_W = NORM_EXP_W
) (
    input logic            clock,
    input logic            reset,
    fp_normalizer_if.slave bus
);

    norm_stage1_t     s1_q, s1_d;
    norm_result_t     s2_q, s2_d;
    logic             s1_valid, s2_valid;
    logic             s1_adv, s2_adv;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_found;
    logic [IDX_W-1:0] sh;
`ifdef FP_NORMALIZER_DENORM_EN
    logic signed [EXP_W-1:0] exp_m1;
`endif

    assign s2_adv        = ~s2_valid | bus.ready_in;
    assign s1_adv        = ~s1_valid | s2_adv;
    assign bus.ready_out = s1_adv;

    priority_encoder #(.N(W), .IDX_W(IDX_W)) u_penc (
        .vec   (bus.mant_in),
        .idx   (enc_idx),
        .found (enc_found)
    );

    always_comb begin
        s1_d.mant  = bus.mant_in;
        s1_d.exp   = bus.exp_in;
        s1_d.idx   = enc_idx;
        s1_d.empty = ~enc_found;
    end

    always_comb begin
        s2_d = '0;
        sh   = '0;
`ifdef FP_NORMALIZER_DENORM_EN
        exp_m1 = s1_q.exp - EXP_W'(1);
`endif
        if (s1_q.empty) begin
            s2_d.zero = 1'b1;
        end else if (s1_q.idx == IDX_W'(W-1)) begin
            s2_d.mant   = s1_q.mant >> 1;
            s2_d.exp    = s1_q.exp + EXP_W'(1);
            s2_d.sticky = s1_q.mant[0];
        end else begin
            // idx == HIDDEN_POS yields sh = 0, which is the pass-through case.
            sh = IDX_W'(HIDDEN_POS) - s1_q.idx;
`ifdef FP_NORMALIZER_DENORM_EN
            if ($signed(s1_q.exp) < 2)
                sh = '0;
            else if ($unsigned(exp_m1) < EXP_W'(sh))
                sh = IDX_W'($unsigned(exp_m1));
`endif
            s2_d.mant = s1_q.mant << sh;
            s2_d.exp  = s1_q.exp - EXP_W'(sh);
        end
        s2_d.tiny = ~s1_q.empty & (($signed(s2_d.exp) <= 0) | ~s2_d.mant[HIDDEN_POS]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= bus.valid_in;
                s1_q     <= s1_d;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                s2_q     <= s2_d;
            end
        end
    end

    assign bus.valid_out  = s2_valid;
    assign bus.mant_out   = s2_q.mant;
    assign bus.exp_out    = s2_q.exp;
    assign bus.sticky_out = s2_q.sticky;
    assign bus.zero_out   = s2_q.zero;
    assign bus.tiny_out   = s2_q.tiny;

endmodule

// File: tb/tb_fp_normalizer.sv
// Self-checking bench for fp_normalizer: directed plan cases, backpressure, reset
// mid-flight and randomized traffic against an arithmetic reference model.
module tb_fp_normalizer;

    typedef struct packed {
        logic [27:0] m;
        logic [9:0]  e;
        logic        s;
        logic        z;
        logic        t;
    } res_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fp_normalizer_if #(.W(28), .EXP_W(10)) bus ();

    fp_normalizer #(.W(28), .EXP_W(10)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    res_t exp_q[$];
    res_t held;
    bit   held_valid;
    int   errors;
    int   checks;
    int   accepted;
    int   emitted;

    function automatic res_t mk(logic [27:0] m, logic [9:0] e, logic s, logic z, logic t);
        res_t r;
        r.m = m; r.e = e; r.s = s; r.z = z; r.t = t;
        return r;
    endfunction

    // Reference: normalize by repeated doubling until the value reaches 2^26.
    function automatic res_t ref_norm(logic [27:0] m, logic [9:0] e);
        res_t        r;
        logic [27:0] mm;
        int          sh;
        r = '0;
        if (m == 28'd0) begin
            r.z = 1'b1;
            return r;
        end
        if (m >= 28'h8000000) begin
            r.m = m / 2;
            r.e = e + 10'd1;
            r.s = m[0];
        end else begin
            mm = m;
            sh = 0;
            while (mm < 28'h4000000) begin
                mm = mm * 2;
                sh++;
            end
`ifdef FP_NORMALIZER_DENORM_EN
            begin
                int es, lim;
                es  = $signed(e);
                lim = (es < 2) ? 0 : es - 1;
                if (sh > lim) sh = lim;
            end
`endif
            r.m = m << sh;
            r.e = e - 10'(sh);
        end
        r.t = ($signed(r.e) <= 0) || (r.m < 28'h4000000);
        return r;
    endfunction

    function automatic res_t observed();
        return {bus.mant_out, bus.exp_out, bus.sticky_out, bus.zero_out, bus.tiny_out};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called at a falling edge; applies inputs, scores this cycle's transfers, advances one cycle.
    task automatic step(input logic v, input logic [27:0] m, input logic [9:0] e,
                        input logic r, input res_t expv);
        bus.valid_in = v;
        bus.mant_in  = m;
        bus.exp_in   = e;
        bus.ready_in = r;
        #1;
        if (v && bus.ready_out) begin
            exp_q.push_back(expv);
            accepted++;
        end
        if (held_valid) begin
            chk("hold_valid", 64'(bus.valid_out), 64'd1);
            if (bus.valid_out) chk("hold_data", 64'(observed()), 64'(held));
        end
        held_valid = 1'b0;
        if (bus.valid_out) begin
            if (r) begin
                if (exp_q.size() == 0) chk("spurious_out", 64'(bus.valid_out), 64'd0);
                else chk("result", 64'(observed()), 64'(exp_q.pop_front()));
                emitted++;
            end else begin
                held       = observed();
                held_valid = 1'b1;
            end
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 28'd0, 10'd0, 1'b1, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          e0;
        logic [27:0] rm;
        logic [9:0]  re;
        logic        rv, rr;

        errors = 0; checks = 0; accepted = 0; emitted = 0; held_valid = 1'b0;
        bus.valid_in = 1'b0; bus.mant_in = '0; bus.exp_in = '0; bus.ready_in = 1'b1;
        reset = 1'b1;
        @(posedge clock); @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("reset_valid_out", 64'(bus.valid_out), 64'd0);
        chk("reset_ready_out", 64'(bus.ready_out), 64'd1);
        chk("reset_data", 64'(observed()), 64'd0);
        @(negedge clock);

        // Pass-through with latency check.
        step(1'b1, 28'h4000000, 10'd100, 1'b1, mk(28'h4000000, 10'd100, 0, 0, 0));
        chk("latency_c1", 64'(bus.valid_out), 64'd0);
        idle(1);
        chk("latency_c2", 64'(bus.valid_out), 64'd1);
        idle(2);

        step(1'b1, 28'h8000001, 10'd100, 1'b1, mk(28'h4000000, 10'd101, 1, 0, 0));
        idle(3);
        step(1'b1, 28'h0000100, 10'd50, 1'b1, mk(28'h4000000, 10'd32, 0, 0, 0));
        idle(3);
        step(1'b1, 28'h0000000, 10'd77, 1'b1, mk(28'h0, 10'd0, 0, 1, 0));
        idle(3);
`ifdef FP_NORMALIZER_DENORM_EN
        step(1'b1, 28'h0000100, 10'd10, 1'b1, mk(28'h0020000, 10'd1, 0, 0, 1));
`else
        step(1'b1, 28'h0000100, 10'd10, 1'b1, mk(28'h4000000, 10'h3F8, 0, 0, 1));
`endif
        idle(3);

        // Backpressure: six offers with ready_in low, only two fit.
        accepted = 0;
        for (int i = 0; i < 6; i++)
            step(1'b1, 28'h4000000, 10'(200 + i), 1'b0, mk(28'h4000000, 10'(200 + i), 0, 0, 0));
        #1;
        chk("bp_accepted", 64'(accepted), 64'd2);
        chk("bp_ready_out", 64'(bus.ready_out), 64'd0);
        @(negedge clock);
        e0 = emitted;
        idle(5);
        chk("bp_emitted", 64'(emitted - e0), 64'd2);
        chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            rm = 28'($urandom) >> $urandom_range(0, 27);
            if ($urandom_range(0, 15) == 0) rm = 28'd0;
            if ($urandom_range(0, 7) == 0) rm[27] = 1'b1;
            re = 10'($urandom);
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 9) < 7);
            step(rv, rm, re, rr, ref_norm(rm, re));
        end
        idle(6);
        chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("rand_idle_valid", 64'(bus.valid_out), 64'd0);

        // Reset with both stages full.
        step(1'b1, 28'h0000001, 10'd40, 1'b0, '0);
        step(1'b1, 28'h0000003, 10'd41, 1'b0, '0);
        #1;
        chk("pre_reset_full", 64'(bus.ready_out), 64'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("mid_reset_valid_out", 64'(bus.valid_out), 64'd0);
        chk("mid_reset_ready_out", 64'(bus.ready_out), 64'd1);
        exp_q.delete();
        held_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        // mant_in = 1 needs the maximum left shift of 26.
        step(1'b1, 28'h0000001, 10'd60, 1'b1, ref_norm(28'h0000001, 10'd60));
        idle(3);
        chk("post_reset_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
